// File: rtl/jstepper_clkgen.sv
// Four-phase CPU clock and one-hot 6-step sequencer with halt,
// resume and single-instruction stepping, all outputs registered.
module jstepper_clkgen #(
  parameter int unsigned DIV        = 1,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             run,
  input  logic             step_req,
  output logic             CLK_clk,
  output logic             CLK_clkd,
  output logic             CLK_clke,
  output logic             CLK_clks,
  output logic [5:0]       STP_bus,
  output logic             running,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUN,
    ST_HALTED
  } state_t;

  localparam logic [7:0] PRE_MAX = 8'(DIV - 1);

  state_t     st_q, st_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] stp_q, stp_d;
  logic [7:0] pre_q, pre_d;
  logic       hp_q, hp_d;

  logic [CNT_W-1:0] cnt_d;
  logic             run_d;
  logic             clk_d, clkd_d;
  logic             clke_d, clks_d;
  logic [5:0]       bus_d;
  logic             go;
  logic             hp_any;

  assign go = run | step_req
            | (AUTO_START && st_q == ST_STOPPED);
  assign hp_any = hp_q | halt;

  always_comb begin
    st_d  = st_q;
    ph_d  = ph_q;
    stp_d = stp_q;
    pre_d = pre_q;
    hp_d  = hp_q;
    cnt_d = instr_count;
    unique case (st_q)
      ST_STOPPED, ST_HALTED: begin
        if (go) begin
          st_d  = ST_RUN;
          ph_d  = 2'd0;
          stp_d = 3'd0;
          pre_d = 8'd0;
          // step_req arms an automatic halt at the next boundary
          hp_d  = step_req & ~run;
        end
      end
      ST_RUN: begin
        hp_d = hp_any;
        if (pre_q != PRE_MAX) begin
          pre_d = pre_q + 8'd1;
        end else begin
          pre_d = 8'd0;
          ph_d  = ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            if (stp_q == 3'd5) begin
              stp_d = 3'd0;
              cnt_d = instr_count + CNT_W'(1);
              if (hp_any) begin
                st_d = ST_HALTED;
                hp_d = 1'b0;
              end
            end else begin
              stp_d = stp_q + 3'd1;
            end
          end
        end
      end
      default: begin
        st_d = ST_STOPPED;
        hp_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    run_d  = (st_d == ST_RUN);
    clk_d  = 1'b0;
    clkd_d = 1'b0;
    clke_d = 1'b0;
    clks_d = 1'b0;
    bus_d  = 6'd0;
    if (run_d) begin
      bus_d = 6'd1 << stp_d;
      unique case (1'b1)
        (ph_d == 2'd0): begin
          clk_d  = 1'b1;
          clke_d = 1'b1;
        end
        (ph_d == 2'd1): begin
          clk_d  = 1'b1;
          clkd_d = 1'b1;
          clke_d = 1'b1;
          clks_d = 1'b1;
        end
        (ph_d == 2'd2): begin
          clkd_d = 1'b1;
          clke_d = 1'b1;
        end
        default: begin
          clk_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= ST_STOPPED;
      ph_q        <= 2'd0;
      stp_q       <= 3'd0;
      pre_q       <= 8'd0;
      hp_q        <= 1'b0;
      instr_count <= '0;
      running     <= 1'b0;
      CLK_clk     <= 1'b0;
      CLK_clkd    <= 1'b0;
      CLK_clke    <= 1'b0;
      CLK_clks    <= 1'b0;
      STP_bus     <= 6'd0;
    end else begin
      st_q        <= st_d;
      ph_q        <= ph_d;
      stp_q       <= stp_d;
      pre_q       <= pre_d;
      hp_q        <= hp_d;
      instr_count <= cnt_d;
      running     <= run_d;
      CLK_clk     <= clk_d;
      CLK_clkd    <= clkd_d;
      CLK_clke    <= clke_d;
      CLK_clks    <= clks_d;
      STP_bus     <= bus_d;
    end
  end

endmodule

// File: tb/tb_jstepper_clkgen.sv
// Scoreboard bench: two configurations driven by shared stimulus,
// checked every cycle against a time-indexed reference model.
module tb_jstepper_clkgen;

  typedef struct packed {
    logic        c;
    logic        cd;
    logic        ce;
    logic        cs;
    logic [5:0]  stp;
    logic        rn;
    logic [15:0] cnt;
  } exp_t;

  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt = 1'b0;
  logic run = 1'b0;
  logic step_req = 1'b0;

  logic a_c, a_cd, a_ce, a_cs, a_rn;
  logic [5:0] a_stp;
  logic [3:0] a_cnt;
  logic b_c, b_cd, b_ce, b_cs, b_rn;
  logic [5:0] b_stp;
  logic [15:0] b_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int md[2];
  int tt[2];
  int hp[2];
  int cn[2];

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  jstepper_clkgen #(.DIV(1), .AUTO_START(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .halt(halt), .run(run),
    .step_req(step_req),
    .CLK_clk(a_c), .CLK_clkd(a_cd), .CLK_clke(a_ce),
    .CLK_clks(a_cs), .STP_bus(a_stp), .running(a_rn),
    .instr_count(a_cnt)
  );

  jstepper_clkgen #(.DIV(3), .AUTO_START(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .halt(halt), .run(run),
    .step_req(step_req),
    .CLK_clk(b_c), .CLK_clkd(b_cd), .CLK_clke(b_ce),
    .CLK_clks(b_cs), .STP_bus(b_stp), .running(b_rn),
    .instr_count(b_cnt)
  );

  // t counts system clocks since the current instruction began
  task automatic model(input int i, input int div,
                       input bit as, input int cw,
                       output exp_t e);
    int ph;
    int sn;
    int hn;
    if (reset) begin
      md[i] = M_STOP;
      tt[i] = 0;
      hp[i] = 0;
      cn[i] = 0;
    end else if (md[i] == M_RUN) begin
      hn = (hp[i] != 0 || halt) ? 1 : 0;
      tt[i] = tt[i] + 1;
      hp[i] = hn;
      if (tt[i] == 24 * div) begin
        tt[i] = 0;
        cn[i] = (cn[i] + 1) % (1 << cw);
        if (hn != 0) begin
          md[i] = M_HALT;
          hp[i] = 0;
        end
      end
    end else if (run || step_req ||
                 (as && md[i] == M_STOP)) begin
      md[i] = M_RUN;
      tt[i] = 0;
      hp[i] = (step_req && !run) ? 1 : 0;
    end
    e = '0;
    e.cnt = 16'(cn[i]);
    if (md[i] == M_RUN) begin
      ph = (tt[i] / div) % 4;
      sn = tt[i] / (4 * div);
      e.rn  = 1'b1;
      e.c   = (ph < 2);
      e.cd  = (ph == 1 || ph == 2);
      e.ce  = (ph != 3);
      e.cs  = (ph == 1);
      e.stp = 6'(1 << sn);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    model(0, 1, 1'b1, 4, e);
    qa.push_back(e);
    model(1, 3, 1'b0, 16, e);
    qb.push_back(e);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse(input bit r, input bit s, input bit h);
    run = r;
    step_req = s;
    halt = h;
    tick();
    run = 1'b0;
    step_req = 1'b0;
    halt = 1'b0;
  endtask

  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        act = {a_c, a_cd, a_ce, a_cs, a_stp, a_rn, 12'd0, a_cnt};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL inst_a cyc %0d got %h want %h",
                   cyc, act, e);
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        act = {b_c, b_cd, b_ce, b_cs, b_stp, b_rn, b_cnt};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL inst_b cyc %0d got %h want %h",
                   cyc, act, e);
        end
      end
    end
  end

  initial begin
    int r;
    ticks(3);
    reset = 1'b0;
    ticks(30);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(60);
    pulse(1'b0, 1'b0, 1'b1);
    ticks(200);
    pulse(1'b0, 1'b1, 1'b0);
    ticks(120);
    pulse(1'b1, 1'b1, 1'b0);
    ticks(100);
    for (int k = 0; k < 100; k++) begin
      if (md[0] == M_RUN && tt[0] == 13) break;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(500);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(100);
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 999));
      halt = (r < 15);
      run = (r >= 15 && r < 30);
      step_req = (r >= 25 && r < 45);
      reset = (r >= 996);
      tick();
    end
    halt = 1'b0;
    run = 1'b0;
    step_req = 1'b0;
    reset = 1'b0;
    ticks(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
